// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter: round-robin burst arbiter driving a registered WIDTH-bit 2:1 mux between sources A and B.
module mux_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output logic             grant_a,
    output logic             grant_b
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t           r_state, w_state_nx;
    logic             r_last, w_last_nx;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_src;
    logic             w_sel, w_can_load, w_x_valid, w_xfer, w_burst_end;
    logic [WIDTH-1:0] w_mux;

    always_comb begin
        w_sel = r_state == OWN_B ? 1'b1 :
                r_state == OWN_A ? 1'b0 :
                (a_valid && b_valid) ? !r_last :
                a_valid ? 1'b0 :
                b_valid ? 1'b1 : r_last;
    end

    assign w_can_load  = !r_out_valid || out_ready;
    assign w_x_valid   = w_sel ? b_valid : a_valid;
    assign w_xfer      = w_x_valid && w_can_load;
    assign w_mux       = w_sel ? b_data : a_data;
    // cnt is 0 in IDLE, so this also covers BURST==1 on the first beat
    assign w_burst_end = (r_cnt + 4'd1) == 4'(BURST);

    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        if (w_xfer) begin
            w_state_nx = w_burst_end ? IDLE : (w_sel ? OWN_B : OWN_A);
            w_last_nx  = w_burst_end ? w_sel : r_last;
            w_cnt_nx   = w_burst_end ? 4'd0 : r_cnt + 4'd1;
        end else if (r_state != IDLE && !w_x_valid) begin
            w_state_nx = IDLE;
            w_last_nx  = w_sel;
            w_cnt_nx   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux;
                r_out_src   <= w_sel;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sel       = w_sel;
    assign a_ready   = !w_sel && w_can_load;
    assign b_ready   = w_sel && w_can_load;
    assign grant_a   = !w_sel && a_valid;
    assign grant_b   = w_sel && b_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
endmodule

// File: tb/tb_mux_port_arbiter.sv
// tb_mux_port_arbiter: directed vector table plus stall/drop/reset sequences; a BURST=1 twin checks alternation.
module tb_mux_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, out_valid, out_src, sel, grant_a, grant_b;
    logic [31:0] out_data;
    logic        a_ready1, b_ready1, out_valid1, out_src1, sel1, grant_a1, grant_b1;
    logic [31:0] out_data1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mux_port_arbiter #(.WIDTH(32), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .sel(sel), .grant_a(grant_a), .grant_b(grant_b)
    );

    mux_port_arbiter #(.WIDTH(32), .BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_src(out_src1), .out_ready(out_ready),
        .sel(sel1), .grant_a(grant_a1), .grant_b(grant_b1)
    );

    typedef struct packed {
        logic        rst;
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
        logic        ordy;
        logic        ar;
        logic        br;
        logic        ov;
        logic [31:0] od;
        logic        os;
        logic        os1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, av, input logic [31:0] ad, input logic bv,
                                input logic [31:0] bd, input logic ordy, ar, br, ov,
                                input logic [31:0] od, input logic os, os1);
        mk = '{r, av, ad, bv, bd, ordy, ar, br, ov, od, os, os1};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, av, input logic [31:0] ad, input logic bv,
                         input logic [31:0] bd, input logic ordy);
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #1;
    endtask

    task automatic post;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst av ad       bv bd       ordy ar br ov od       os os1
        tv.push_back(mk(1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0));
        tv.push_back(mk(0, 1, 32'h11, 0, 32'h0,  1, 1, 0, 1, 32'h11, 0, 0));
        tv.push_back(mk(0, 1, 32'h22, 0, 32'h0,  1, 1, 0, 1, 32'h22, 0, 0));
        tv.push_back(mk(0, 1, 32'h33, 0, 32'h0,  1, 1, 0, 1, 32'h33, 0, 0));
        tv.push_back(mk(0, 1, 32'h44, 0, 32'h0,  1, 1, 0, 1, 32'h44, 0, 0));
        tv.push_back(mk(0, 1, 32'h55, 0, 32'h0,  1, 1, 0, 1, 32'h55, 0, 0));
        tv.push_back(mk(0, 1, 32'h66, 0, 32'h0,  1, 1, 0, 1, 32'h66, 0, 0));
        tv.push_back(mk(0, 0, 32'h77, 0, 32'h0,  1, 1, 0, 0, 32'h66, 0, 0));
        tv.push_back(mk(1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0));
        tv.push_back(mk(0, 1, 32'hA1, 1, 32'hB1, 1, 1, 0, 1, 32'hA1, 0, 0));
        tv.push_back(mk(0, 1, 32'hA2, 1, 32'hB1, 1, 1, 0, 1, 32'hA2, 0, 1));
        tv.push_back(mk(0, 1, 32'hA3, 1, 32'hB1, 1, 1, 0, 1, 32'hA3, 0, 0));
        tv.push_back(mk(0, 1, 32'hA4, 1, 32'hB1, 1, 1, 0, 1, 32'hA4, 0, 1));
        tv.push_back(mk(0, 1, 32'hA5, 1, 32'hB1, 1, 0, 1, 1, 32'hB1, 1, 0));
        tv.push_back(mk(0, 1, 32'hA5, 1, 32'hB2, 1, 0, 1, 1, 32'hB2, 1, 1));
        tv.push_back(mk(0, 1, 32'hA5, 1, 32'hB3, 1, 0, 1, 1, 32'hB3, 1, 0));
        tv.push_back(mk(0, 1, 32'hA5, 1, 32'hB4, 1, 0, 1, 1, 32'hB4, 1, 1));
        tv.push_back(mk(0, 1, 32'hA5, 1, 32'hB5, 1, 1, 0, 1, 32'hA5, 0, 0));
        tv.push_back(mk(0, 1, 32'hA6, 1, 32'hB5, 1, 1, 0, 1, 32'hA6, 0, 1));
        tv.push_back(mk(0, 1, 32'hA7, 1, 32'hB5, 1, 1, 0, 1, 32'hA7, 0, 0));
        tv.push_back(mk(0, 1, 32'hA8, 1, 32'hB5, 1, 1, 0, 1, 32'hA8, 0, 1));

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].av, tv[i].ad, tv[i].bv, tv[i].bd, tv[i].ordy);
            if (!tv[i].rst) begin
                chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(tv[i].ar));
                chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(tv[i].br));
            end
            post();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            chk($sformatf("v%0d_out_data", i), out_data, tv[i].od);
            chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(tv[i].os));
            chk($sformatf("v%0d_b1_out_src", i), 32'(out_src1), 32'(tv[i].os1));
        end

        // stall mid-burst at cnt=2 with B also waiting
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        post();
        drive(0, 1, 32'hC1, 1, 32'hD1, 1);
        chk("stall_pre_a_ready", 32'(a_ready), 32'd1);
        post();
        chk("stall_pre_c1", out_data, 32'hC1);
        drive(0, 1, 32'hC2, 1, 32'hD1, 1);
        post();
        chk("stall_pre_c2", out_data, 32'hC2);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 32'hC3, 1, 32'hD1, 0);
            chk($sformatf("stall%0d_a_ready", k), 32'(a_ready), 32'd0);
            chk($sformatf("stall%0d_b_ready", k), 32'(b_ready), 32'd0);
            post();
            chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_out_data", k), out_data, 32'hC2);
        end
        drive(0, 1, 32'hC3, 1, 32'hD1, 1);
        chk("resume_a_ready", 32'(a_ready), 32'd1);
        post();
        chk("resume_c3", out_data, 32'hC3);
        drive(0, 1, 32'hC4, 1, 32'hD1, 1);
        post();
        chk("resume_c4", out_data, 32'hC4);
        drive(0, 1, 32'hC5, 1, 32'hD1, 1);
        chk("handover_b_ready", 32'(b_ready), 32'd1);
        post();
        chk("handover_data", out_data, 32'hD1);
        chk("handover_src", 32'(out_src), 32'd1);

        // B drops valid at cnt=1 while A is waiting
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        post();
        drive(0, 0, 32'h0, 1, 32'hE1, 1);
        chk("drop_b_ready", 32'(b_ready), 32'd1);
        post();
        chk("drop_e1", out_data, 32'hE1);
        drive(0, 1, 32'hF1, 0, 32'hE2, 1);
        chk("drop_a_ready", 32'(a_ready), 32'd0);
        chk("drop_grant_a", 32'(grant_a), 32'd0);
        chk("drop_grant_b", 32'(grant_b), 32'd0);
        post();
        chk("drop_bubble", 32'(out_valid), 32'd0);
        drive(0, 1, 32'hF1, 1, 32'hE2, 1);
        chk("after_drop_a_ready", 32'(a_ready), 32'd1);
        chk("after_drop_grant_a", 32'(grant_a), 32'd1);
        post();
        chk("after_drop_data", out_data, 32'hF1);
        chk("after_drop_src", 32'(out_src), 32'd0);

        // reset while OWN_A holds a beat
        drive(1, 1, 32'hF2, 1, 32'hE2, 1);
        post();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        drive(0, 1, 32'hF2, 1, 32'hE2, 1);
        chk("rst_tie_a_ready", 32'(a_ready), 32'd1);
        chk("rst_tie_b_ready", 32'(b_ready), 32'd0);
        post();
        chk("rst_tie_data", out_data, 32'hF2);
        chk("rst_tie_src", 32'(out_src), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
